// File: rtl/pc_pkg.sv
// Shared types for the program-counter unit: next-PC mode encodings.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_SEQ    = 3'd0,
    PC_JUMP   = 3'd1,
    PC_BRANCH = 3'd2,
    PC_CALL   = 3'd3,
    PC_RET    = 3'd4
  } pc_mode_e;

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between the fetch control logic and the PC unit.
interface pc_unit_if #(
  parameter int WIDTH = 16,
  parameter int OFF_W = 8
);
  logic             en;
  logic             stall;
  logic [2:0]       mode;     // 5..7 reserved, behave as SEQ
  logic [WIDTH-1:0] target;
  logic [OFF_W-1:0] offset;
  logic             clr_err;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_inc;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_ovf;
  logic             ras_unf;

  modport master (
    output en, stall, mode, target, offset, clr_err,
    input  pc, pc_inc, ras_empty, ras_full, ras_ovf, ras_unf
  );

  modport slave (
    input  en, stall, mode, target, offset, clr_err,
    output pc, pc_inc, ras_empty, ras_full, ras_ovf, ras_unf
  );
endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack: write pointer plus count; a push when full
// overwrites the oldest entry. push/pop arrive already qualified and exclusive.
module ras_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             ovf_evt,
  output logic             unf_evt
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [CW-1:0]    cnt;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign top     = mem[wp - PW'(1)];
  assign ovf_evt = push & full;
  assign unf_evt = pop & empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp  <= '0;
      cnt <= '0;
    end else if (push) begin
      // wp wraps naturally, so a full push lands on the oldest slot
      wp <= wp + PW'(1);
      if (!full) cnt <= cnt + CW'(1);
    end else if (pop && !empty) begin
      wp  <= wp - PW'(1);
      cnt <= cnt - CW'(1);
    end
  end

  // contents are don't-care after reset, so no reset on the storage
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with SEQ/JUMP/BRANCH/CALL/RET next-PC select, return-address
// stack and sticky overflow/underflow flags.
module pc_unit
  import pc_pkg::*;
#(
  parameter int          WIDTH     = 16,
  parameter int          OFF_W     = 8,
  parameter int          RAS_DEPTH = 4,
  parameter int unsigned RESET_VEC = 0
) (
  input logic        clk,
  input logic        rst,
  pc_unit_if.slave   bus
);
  logic [WIDTH-1:0] pc_q, pc_inc, br_pc, nxt_pc, top;
  logic             adv, push, pop;
  logic             empty, full, ovf_evt, unf_evt;
  logic             ovf_q, unf_q;

  assign adv    = bus.en & ~bus.stall;
  assign pc_inc = pc_q + WIDTH'(1);
  // size cast of a signed operand sign-extends the offset
  assign br_pc  = pc_q + WIDTH'($signed(bus.offset));

  always_comb begin
    nxt_pc = pc_inc;
    push   = 1'b0;
    pop    = 1'b0;
    case (bus.mode)
      PC_JUMP:   nxt_pc = bus.target;
      PC_BRANCH: nxt_pc = br_pc;
      PC_CALL: begin
        nxt_pc = bus.target;
        push   = adv;
      end
      PC_RET: begin
        pop = adv;
        if (!empty) nxt_pc = top;
      end
      default: nxt_pc = pc_inc;
    endcase
  end

  ras_stack #(.WIDTH(WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .din     (pc_inc),
    .top     (top),
    .empty   (empty),
    .full    (full),
    .ovf_evt (ovf_evt),
    .unf_evt (unf_evt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= WIDTH'(RESET_VEC);
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (adv) pc_q <= nxt_pc;
      // a new event wins over a coincident clear
      ovf_q <= (ovf_q & ~bus.clr_err) | ovf_evt;
      unf_q <= (unf_q & ~bus.clr_err) | unf_evt;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_inc    = pc_inc;
  assign bus.ras_empty = empty;
  assign bus.ras_full  = full;
  assign bus.ras_ovf   = ovf_q;
  assign bus.ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_pc_unit;
  localparam int W = 16;
  localparam int OW = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pc_unit_if #(.WIDTH(W), .OFF_W(OW)) bus ();

  pc_unit #(.WIDTH(W), .OFF_W(OW), .RAS_DEPTH(D), .RESET_VEC(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_run = 0;
  int n_fail = 0;

  // reference model
  int unsigned mpc = 0;
  int unsigned mstk[$];
  bit movf = 1'b0;
  bit munf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".pc"},     32'(bus.pc),     mpc);
    chk({tag, ".pc_inc"}, 32'(bus.pc_inc), (mpc + 1) & 32'hFFFF);
    chk({tag, ".empty"},  32'(bus.ras_empty), 32'(mstk.size() == 0));
    chk({tag, ".full"},   32'(bus.ras_full),  32'(mstk.size() == D));
    chk({tag, ".ovf"},    32'(bus.ras_ovf),   32'(movf));
    chk({tag, ".unf"},    32'(bus.ras_unf),   32'(munf));
  endtask

  task automatic model_reset();
    mpc = 0;
    mstk.delete();
    movf = 1'b0;
    munf = 1'b0;
  endtask

  // drive one cycle, advance the model at the edge, compare 1 time unit later
  task automatic step(input string tag, input bit e, input bit s, input logic [2:0] m,
                      input logic [15:0] t, input logic [7:0] o, input bit c);
    bit set_o, set_u;
    bus.en = e; bus.stall = s; bus.mode = m;
    bus.target = t; bus.offset = o; bus.clr_err = c;
    @(posedge clk);
    set_o = 1'b0;
    set_u = 1'b0;
    if (e && !s) begin
      case (m)
        3'd1: mpc = t;
        3'd2: mpc = (mpc + 32'($signed(o))) & 32'hFFFF;
        3'd3: begin
          mstk.push_back((mpc + 1) & 32'hFFFF);
          if (mstk.size() > D) begin
            void'(mstk.pop_front());
            set_o = 1'b1;
          end
          mpc = t;
        end
        3'd4: begin
          if (mstk.size() > 0) mpc = mstk.pop_back();
          else begin
            mpc = (mpc + 1) & 32'hFFFF;
            set_u = 1'b1;
          end
        end
        default: mpc = (mpc + 1) & 32'hFFFF;
      endcase
    end
    movf = (movf && !c) || set_o;
    munf = (munf && !c) || set_u;
    #1;
    chk_model(tag);
  endtask

  initial begin
    bus.en = 1'b0; bus.stall = 1'b0; bus.mode = 3'd0;
    bus.target = '0; bus.offset = '0; bus.clr_err = 1'b0;

    // reset state
    #12;
    chk("rst.pc", 32'(bus.pc), 32'h0);
    chk("rst.pc_inc", 32'(bus.pc_inc), 32'h1);
    chk("rst.empty", 32'(bus.ras_empty), 32'h1);
    chk("rst.full", 32'(bus.ras_full), 32'h0);
    @(negedge clk) rst = 1'b1;

    // some traffic, then an asynchronous reset mid-cycle
    step("pre", 1, 0, 3'd3, 16'h1234, 8'h00, 0);
    step("pre", 1, 0, 3'd0, 16'h0000, 8'h00, 0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("arst.pc", 32'(bus.pc), 32'h0);
    chk("arst.empty", 32'(bus.ras_empty), 32'h1);
    @(negedge clk) rst = 1'b1;
    step("seq1", 1, 0, 3'd0, 16'h0, 8'h0, 0);
    chk("seq1.pc", 32'(bus.pc), 32'h1);
    step("seq2", 1, 0, 3'd0, 16'h0, 8'h0, 0);
    step("seq3", 1, 0, 3'd0, 16'h0, 8'h0, 0);
    chk("seq3.pc", 32'(bus.pc), 32'h3);
    chk("seq3.pc_inc", 32'(bus.pc_inc), 32'h4);
    chk("seq3.empty", 32'(bus.ras_empty), 32'h1);

    // branch wrap in both directions
    step("j2", 1, 0, 3'd1, 16'h0002, 8'h0, 0);
    step("brn", 1, 0, 3'd2, 16'h0, 8'hFC, 0);
    chk("brn.pc", 32'(bus.pc), 32'hFFFE);
    step("brp", 1, 0, 3'd2, 16'h0, 8'h05, 0);
    chk("brp.pc", 32'(bus.pc), 32'h0003);

    // nested call/return
    step("j10", 1, 0, 3'd1, 16'h0010, 8'h0, 0);
    step("call1", 1, 0, 3'd3, 16'h0100, 8'h0, 0);
    chk("call1.pc", 32'(bus.pc), 32'h0100);
    step("call2", 1, 0, 3'd3, 16'h0200, 8'h0, 0);
    chk("call2.pc", 32'(bus.pc), 32'h0200);
    step("ret1", 1, 0, 3'd4, 16'h0, 8'h0, 0);
    chk("ret1.pc", 32'(bus.pc), 32'h0101);
    step("ret2", 1, 0, 3'd4, 16'h0, 8'h0, 0);
    chk("ret2.pc", 32'(bus.pc), 32'h0011);
    chk("ret2.empty", 32'(bus.ras_empty), 32'h1);

    // overflow: 5 calls from A..E, 4 returns, A+1 lost
    step("jA", 1, 0, 3'd1, 16'h0A00, 8'h0, 0);
    for (int i = 1; i <= 5; i++) step("ovc", 1, 0, 3'd3, 16'(i * 16'h1000), 8'h0, 0);
    chk("ovf.flag", 32'(bus.ras_ovf), 32'h1);
    chk("ovf.full", 32'(bus.ras_full), 32'h1);
    for (int i = 4; i >= 1; i--) begin
      step("ovr", 1, 0, 3'd4, 16'h0, 8'h0, 0);
      chk("ovr.pc", 32'(bus.pc), 32'(i * 32'h1000 + 1));
    end
    chk("ovr.empty", 32'(bus.ras_empty), 32'h1);
    step("ovclr", 1, 0, 3'd0, 16'h0, 8'h0, 1);
    chk("ovclr.flag", 32'(bus.ras_ovf), 32'h0);

    // underflow, clear, and set-beats-clear
    step("j40", 1, 0, 3'd1, 16'h0040, 8'h0, 0);
    step("unf", 1, 0, 3'd4, 16'h0, 8'h0, 0);
    chk("unf.pc", 32'(bus.pc), 32'h0041);
    chk("unf.flag", 32'(bus.ras_unf), 32'h1);
    step("unclr", 0, 0, 3'd0, 16'h0, 8'h0, 1);
    chk("unclr.flag", 32'(bus.ras_unf), 32'h0);
    step("unset", 1, 0, 3'd4, 16'h0, 8'h0, 1);
    chk("unset.flag", 32'(bus.ras_unf), 32'h1);
    step("unclr2", 1, 0, 3'd0, 16'h0, 8'h0, 1);

    // stall overrides enable; en=0 holds too
    step("j50", 1, 0, 3'd1, 16'h0050, 8'h0, 0);
    step("stall", 1, 1, 3'd3, 16'h0300, 8'h0, 0);
    chk("stall.pc", 32'(bus.pc), 32'h0050);
    chk("stall.empty", 32'(bus.ras_empty), 32'h1);
    step("noen", 0, 0, 3'd3, 16'h0300, 8'h0, 0);
    chk("noen.pc", 32'(bus.pc), 32'h0050);
    step("unstall", 1, 0, 3'd3, 16'h0300, 8'h0, 0);
    chk("unstall.pc", 32'(bus.pc), 32'h0300);
    chk("unstall.empty", 32'(bus.ras_empty), 32'h0);

    // random traffic, call/ret weighted to exercise the stack edges
    for (int i = 0; i < 400; i++) begin
      logic [2:0] m;
      int r;
      r = int'($urandom_range(0, 9));
      m = (r < 3) ? 3'd3 : (r < 6) ? 3'd4 : 3'($urandom_range(0, 7));
      step("rnd", $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, m,
           16'($urandom), 8'($urandom), $urandom_range(0, 9) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
